l2_noc_trace: RTL and testbench
===============================

// Module: l2_noc_trace
// PURPOSE
//  Parametrised L2 NoC debug monitor: passively observes NUM_CH valid/ready/data channels
//  (default: NoC1 in, NoC2 out, NoC3 in) at the L2 boundary. Counts transfers and stalls per
//  channel and captures enabled transfers, timestamped, into a trace FIFO. Software/debug
//  logic drains the FIFO over a valid/ready port. Never drives or backpressures the NoC.
// PARAMETERS
//  NUM_CH   3    monitored channels (>=1)
//  DATA_W   64   flit width (`NOC_DATA_WIDTH)
//  DEPTH    16   trace FIFO entries, power of 2, >=2
//  TS_W     16   timestamp width
//  CNT_W    32   per-channel counter width
//  CH_W     $clog2(NUM_CH) or 1 if NUM_CH==1 (derived, localparam)
// PORTS
//  clk        in   1                 clock
//  rst        in   1                 synchronous reset, active-high
//  mon_valid  in   NUM_CH            observed valid, bit i = channel i
//  mon_ready  in   NUM_CH            observed ready
//  mon_data   in   NUM_CH*DATA_W     observed data, channel i at [i*DATA_W +: DATA_W]
//  ch_en      in   NUM_CH            capture enable per channel (counters always run)
//  wrap_mode  in   1                 0: drop new on full; 1: overwrite oldest on full
//  clear      in   1                 sync clear of counters, FIFO, timestamp
//  trc_valid  out  1                 FIFO head valid
//  trc_ready  in   1                 consumer accepts head
//  trc_data   out  CH_W+TS_W+DATA_W  head entry {ch_id, timestamp, data}
//  level      out  $clog2(DEPTH)+1   FIFO occupancy
//  xfer_cnt   out  NUM_CH*CNT_W      transfers per channel (valid&ready cycles)
//  stall_cnt  out  NUM_CH*CNT_W      stall cycles per channel (valid&!ready)
//  drop_cnt   out  CNT_W             fires lost to arbitration, full-drop or overwrite
// BEHAVIOUR
//  - Reset/clear: all counters, level, timestamp, RR pointer = 0; trc_valid=0; trc_data=0.
//    clear dominates any same-cycle capture, pop or count.
//  - ts: free-running, +1 every cycle, wraps 2^TS_W-1 -> 0. Entry carries ts of fire cycle.
//  - fire[i] = mon_valid[i] & mon_ready[i]; cand[i] = fire[i] & ch_en[i].
//  - Counters: xfer_cnt[i] += fire[i]; stall_cnt[i] += valid&!ready; all saturate at all-ones.
//  - Arbitration: max one write per cycle; round-robin over cand starting at rr_ptr; winner
//    written, rr_ptr <= winner+1 (mod NUM_CH); rr_ptr unchanged if no cand.
//    Each losing cand adds 1 to drop_cnt (popcount(cand)-1 per cycle, saturating).
//  - Latency: cand in cycle t -> entry in FIFO at t+1; trc_valid=1 at t+1 if FIFO was empty.
//    No bypass; trc_* are registered/array outputs.
//  - Pop: trc_valid & trc_ready removes head at clock edge.
//  - Full (level==DEPTH), write pending:
//    pop same cycle -> write accepted, level unchanged, no drop.
//    no pop, wrap_mode=0 -> new entry discarded, drop_cnt+1.
//    no pop, wrap_mode=1 -> oldest discarded (rd ptr +1), new written, level stays DEPTH,
//    drop_cnt+1. Head (trc_data) may change while trc_valid&!trc_ready only in this case.
//  - Empty: trc_valid=0, trc_ready ignored, level never underflows.
//  - Pointers wrap mod DEPTH; level = wr-rd with extra MSB.
//  - wrap_mode and ch_en sampled every cycle; changing them never corrupts stored entries.
// TESTING
//  1 rst held 2 cycles, then idle 10 cycles -> all outputs 0 except ts-driven nothing; level=0.
//  2 ch1 fires once data=64'hA5, ch_en=3'b111, trc_ready=0 -> next cycle trc_valid=1,
//    trc_data={1,ts_fire,64'hA5}, xfer_cnt[1]=1, level=1.
//  3 all 3 channels fire same cycle x3 consecutive -> grants ch0,ch1,ch2 in order, drop_cnt=6.
//  4 wrap_mode=0, ch0 fires DEPTH+3 times, no pop -> level=16, drop_cnt=3, head=first flit;
//    repeat with wrap_mode=1 -> head=4th flit, drop_cnt=3.
//  5 ch2 valid=1 ready=0 for 5 cycles then ready=1 -> stall_cnt[2]=5, xfer_cnt[2]=1.
//  6 FIFO full, simultaneous fire+pop -> level stays 16, no drop; clear with fire same cycle
//    -> level=0, counters 0, no entry written.

Source files
------------

// File: rtl/l2_noc_trace.sv
// Passive L2 NoC debug monitor: per-channel transfer/stall counters plus a timestamped,
// round-robin arbitrated trace FIFO drained over a valid/ready port.
module l2_noc_trace #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16,
    parameter int CNT_W  = 32,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW    = $clog2(DEPTH),
    localparam int ENT_W = CH_W + TS_W + DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        mon_valid,
    input  logic [NUM_CH-1:0]        mon_ready,
    input  logic [NUM_CH*DATA_W-1:0] mon_data,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic                     wrap_mode,
    input  logic                     clear,
    output logic                     trc_valid,
    input  logic                     trc_ready,
    output logic [ENT_W-1:0]         trc_data,
    output logic [AW:0]              level,
    output logic [NUM_CH*CNT_W-1:0]  xfer_cnt,
    output logic [NUM_CH*CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [CH_W:0] INC_ONE = {{CH_W{1'b0}}, 1'b1};

    function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        s = (s >= NUM_CH) ? (s - NUM_CH) : s;
        return s[CH_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CH_W:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-CH_W){1'b0}}, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    logic [TS_W-1:0]         ts_q;
    logic [CH_W-1:0]         rr_q, rr_d;
    logic [AW:0]             wr_q, wr_d, rd_q, rd_d;
    logic [NUM_CH*CNT_W-1:0] xfer_q, xfer_d, stall_q, stall_d;
    logic [CNT_W-1:0]        drop_q, drop_d;
    logic [ENT_W-1:0]        mem_q [DEPTH];

    logic [NUM_CH-1:0] cand_s;
    logic              any_s;
    logic [CH_W-1:0]   win_s;
    logic [DATA_W-1:0] win_data_s;
    logic [CH_W:0]     ncand_s;
    logic [CH_W:0]     drop_inc_s;
    logic              full_s, pop_s, wr_en_s;

    assign level     = wr_q - rd_q;
    assign trc_valid = (wr_q != rd_q);
    assign trc_data  = trc_valid ? mem_q[rd_q[AW-1:0]] : {ENT_W{1'b0}};
    assign xfer_cnt  = xfer_q;
    assign stall_cnt = stall_q;
    assign drop_cnt  = drop_q;

    // Round-robin pick among capture candidates, scanning upward from rr_q.
    always_comb begin
        cand_s     = mon_valid & mon_ready & ch_en;
        any_s      = 1'b0;
        win_s      = {CH_W{1'b0}};
        ncand_s    = {(CH_W+1){1'b0}};
        win_data_s = {DATA_W{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            ncand_s = ncand_s + {{CH_W{1'b0}}, cand_s[k]};
            if (!any_s && cand_s[rr_idx(rr_q, k)]) begin
                any_s = 1'b1;
                win_s = rr_idx(rr_q, k);
            end else begin
                any_s = any_s;
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (win_s == CH_W'(k)) begin
                win_data_s = mon_data[k*DATA_W +: DATA_W];
            end else begin
                win_data_s = win_data_s;
            end
        end
    end

    // FIFO pointer update; a full FIFO either drops the newcomer or evicts the oldest entry.
    always_comb begin
        full_s     = (level == (AW+1)'(DEPTH));
        pop_s      = trc_valid & trc_ready;
        wr_en_s    = 1'b0;
        wr_d       = wr_q;
        rd_d       = pop_s ? (rd_q + PTR_ONE) : rd_q;
        rr_d       = rr_q;
        drop_inc_s = {(CH_W+1){1'b0}};
        if (any_s) begin
            rr_d       = rr_idx(win_s, 1);
            drop_inc_s = ncand_s - INC_ONE;
            if (!full_s || pop_s) begin
                wr_en_s = 1'b1;
                wr_d    = wr_q + PTR_ONE;
            end else if (wrap_mode) begin
                wr_en_s    = 1'b1;
                wr_d       = wr_q + PTR_ONE;
                rd_d       = rd_q + PTR_ONE;
                drop_inc_s = ncand_s;
            end else begin
                drop_inc_s = ncand_s;
            end
        end else begin
            rr_d = rr_q;
        end
        drop_d = sat_add(drop_q, drop_inc_s);
    end

    // Per-channel saturating transfer and stall counters.
    always_comb begin
        xfer_d  = xfer_q;
        stall_d = stall_q;
        for (int k = 0; k < NUM_CH; k++) begin
            xfer_d[k*CNT_W +: CNT_W]  = sat_add(xfer_q[k*CNT_W +: CNT_W],
                                                {{CH_W{1'b0}}, mon_valid[k] & mon_ready[k]});
            stall_d[k*CNT_W +: CNT_W] = sat_add(stall_q[k*CNT_W +: CNT_W],
                                                {{CH_W{1'b0}}, mon_valid[k] & ~mon_ready[k]});
        end
    end

    // Control state; clear acts as a synchronous reset and overrides everything else.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ts_q    <= {TS_W{1'b0}};
            rr_q    <= {CH_W{1'b0}};
            wr_q    <= {(AW+1){1'b0}};
            rd_q    <= {(AW+1){1'b0}};
            xfer_q  <= {(NUM_CH*CNT_W){1'b0}};
            stall_q <= {(NUM_CH*CNT_W){1'b0}};
            drop_q  <= {CNT_W{1'b0}};
        end else begin
            ts_q    <= ts_q + {{(TS_W-1){1'b0}}, 1'b1};
            rr_q    <= rr_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            xfer_q  <= xfer_d;
            stall_q <= stall_d;
            drop_q  <= drop_d;
        end
    end

    // Trace storage is not reset; empty slots are masked at the output.
    always_ff @(posedge clk) begin
        if (wr_en_s && !rst && !clear) begin
            mem_q[wr_q[AW-1:0]] <= {win_s, ts_q, win_data_s};
        end
    end

endmodule

// File: tb/tb_l2_noc_trace.sv
// Self-checking bench for l2_noc_trace: vector table, directed corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_l2_noc_trace;

    localparam int NUM_CH = 3;
    localparam int DEPTH  = 16;
    localparam int ENT_W  = 82;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, wrap_mode, clear, trc_ready, trc_valid;
    logic [2:0]   mon_valid, mon_ready, ch_en;
    logic [191:0] mon_data;
    logic [81:0]  trc_data;
    logic [4:0]   level;
    logic [95:0]  xfer_cnt, stall_cnt;
    logic [31:0]  drop_cnt;

    int checks   = 0;
    int failures = 0;

    l2_noc_trace dut (
        .clk(clk), .rst(rst), .mon_valid(mon_valid), .mon_ready(mon_ready),
        .mon_data(mon_data), .ch_en(ch_en), .wrap_mode(wrap_mode), .clear(clear),
        .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_data(trc_data), .level(level),
        .xfer_cnt(xfer_cnt), .stall_cnt(stall_cnt), .drop_cnt(drop_cnt)
    );

    // Reference model state
    logic [ENT_W-1:0] m_q[$];
    longint m_xfer[3], m_stall[3], m_drop;
    int m_ts, m_rr;

    function automatic longint sat32(input longint v);
        return (v > 64'h0000_0000_FFFF_FFFF) ? 64'h0000_0000_FFFF_FFFF : v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        logic [2:0] cand;
        logic [ENT_W-1:0] ent;
        int n, w;
        if (rst || clear) begin
            m_q.delete();
            for (int i = 0; i < 3; i++) begin m_xfer[i] = 0; m_stall[i] = 0; end
            m_drop = 0; m_ts = 0; m_rr = 0;
            return;
        end
        for (int i = 0; i < 3; i++) begin
            if (mon_valid[i] && mon_ready[i]) m_xfer[i] = sat32(m_xfer[i] + 1);
            if (mon_valid[i] && !mon_ready[i]) m_stall[i] = sat32(m_stall[i] + 1);
        end
        cand = mon_valid & mon_ready & ch_en;
        n = $countones(cand);
        w = -1;
        for (int k = 0; k < 3; k++)
            if (w < 0 && cand[(m_rr + k) % 3]) w = (m_rr + k) % 3;
        if (trc_ready && m_q.size() > 0) void'(m_q.pop_front());
        if (w >= 0) begin
            m_drop = sat32(m_drop + n - 1);
            m_rr = (w + 1) % 3;
            ent = {2'(w), 16'(m_ts), mon_data[w*64 +: 64]};
            if (m_q.size() < DEPTH) m_q.push_back(ent);
            else if (wrap_mode) begin
                void'(m_q.pop_front());
                m_q.push_back(ent);
                m_drop = sat32(m_drop + 1);
            end else m_drop = sat32(m_drop + 1);
        end
        m_ts = (m_ts + 1) % 65536;
    endtask

    task automatic check_model();
        chk("trc_valid", 128'(trc_valid), 128'(m_q.size() != 0));
        chk("trc_data", 128'(trc_data), (m_q.size() != 0) ? 128'(m_q[0]) : 128'd0);
        chk("level", 128'(level), 128'(m_q.size()));
        for (int i = 0; i < 3; i++) begin
            chk("xfer_cnt", 128'(xfer_cnt[i*32 +: 32]), 128'(m_xfer[i]));
            chk("stall_cnt", 128'(stall_cnt[i*32 +: 32]), 128'(m_stall[i]));
        end
        chk("drop_cnt", 128'(drop_cnt), 128'(m_drop));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic quiet();
        mon_valid = 3'b000; mon_ready = 3'b000; trc_ready = 1'b0; clear = 1'b0;
    endtask

    task automatic do_clear();
        quiet();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  v;
        logic [2:0]  r;
        logic        tr;
        logic        exp_valid;
        logic [4:0]  exp_level;
        logic [31:0] exp_x0;
        logic [31:0] exp_x1;
        logic [31:0] exp_s0;
        logic [31:0] exp_drop;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int ts_fire;
        int phase;

        tbl[0] = '{3'b010, 3'b010, 1'b0, 1'b1, 5'd1, 32'd0, 32'd1, 32'd0, 32'd0};
        tbl[1] = '{3'b000, 3'b000, 1'b0, 1'b1, 5'd1, 32'd0, 32'd1, 32'd0, 32'd0};
        tbl[2] = '{3'b001, 3'b000, 1'b0, 1'b1, 5'd1, 32'd0, 32'd1, 32'd1, 32'd0};
        tbl[3] = '{3'b001, 3'b001, 1'b1, 1'b1, 5'd1, 32'd1, 32'd1, 32'd1, 32'd0};
        tbl[4] = '{3'b011, 3'b011, 1'b0, 1'b1, 5'd2, 32'd2, 32'd2, 32'd1, 32'd1};
        tbl[5] = '{3'b000, 3'b000, 1'b1, 1'b1, 5'd1, 32'd2, 32'd2, 32'd1, 32'd1};
        tbl[6] = '{3'b000, 3'b000, 1'b1, 1'b0, 5'd0, 32'd2, 32'd2, 32'd1, 32'd1};
        tbl[7] = '{3'b000, 3'b000, 1'b1, 1'b0, 5'd0, 32'd2, 32'd2, 32'd1, 32'd1};

        // Reset for two cycles, then idle
        quiet();
        ch_en = 3'b111; wrap_mode = 1'b0; mon_data = '0;
        rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        chk("rst_level", 128'(level), 128'd0);
        chk("rst_valid", 128'(trc_valid), 128'd0);
        chk("rst_data", 128'(trc_data), 128'd0);
        chk("rst_xfer", 128'(xfer_cnt), 128'd0);
        chk("rst_stall", 128'(stall_cnt), 128'd0);
        chk("rst_drop", 128'(drop_cnt), 128'd0);

        // Vector table
        do_clear();
        mon_data[0 +: 64] = 64'h10; mon_data[64 +: 64] = 64'hA5; mon_data[128 +: 64] = 64'h22;
        for (int i = 0; i < 8; i++) begin
            mon_valid = tbl[i].v; mon_ready = tbl[i].r; trc_ready = tbl[i].tr;
            ts_fire = m_ts;
            cycle();
            chk("tbl_valid", 128'(trc_valid), 128'(tbl[i].exp_valid));
            chk("tbl_level", 128'(level), 128'(tbl[i].exp_level));
            chk("tbl_xfer0", 128'(xfer_cnt[31:0]), 128'(tbl[i].exp_x0));
            chk("tbl_xfer1", 128'(xfer_cnt[63:32]), 128'(tbl[i].exp_x1));
            chk("tbl_stall0", 128'(stall_cnt[31:0]), 128'(tbl[i].exp_s0));
            chk("tbl_drop", 128'(drop_cnt), 128'(tbl[i].exp_drop));
            if (i == 0) chk("first_entry", 128'(trc_data), 128'({2'd1, 16'(ts_fire), 64'hA5}));
        end

        // All channels fire three cycles in a row: grants rotate 0,1,2
        do_clear();
        mon_valid = 3'b111; mon_ready = 3'b111;
        cycle(); cycle(); cycle();
        chk("rr_drop", 128'(drop_cnt), 128'd6);
        chk("rr_level", 128'(level), 128'd3);
        quiet();
        trc_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("rr_grant", 128'(trc_data[81:80]), 128'(k));
            cycle();
        end

        // Full FIFO with drop-new, then with overwrite-oldest
        for (int mode = 0; mode < 2; mode++) begin
            do_clear();
            wrap_mode = mode[0];
            mon_valid = 3'b001; mon_ready = 3'b001;
            for (int k = 1; k <= DEPTH + 3; k++) begin
                mon_data[0 +: 64] = 64'(k);
                cycle();
            end
            quiet();
            chk("full_level", 128'(level), 128'd16);
            chk("full_drop", 128'(drop_cnt), 128'd3);
            chk("full_head", 128'(trc_data[63:0]), mode ? 128'd4 : 128'd1);
        end

        // Full FIFO: fire and pop in the same cycle
        mon_valid = 3'b001; mon_ready = 3'b001; trc_ready = 1'b1;
        mon_data[0 +: 64] = 64'd100;
        cycle();
        chk("fullpop_level", 128'(level), 128'd16);
        chk("fullpop_drop", 128'(drop_cnt), 128'd3);
        chk("fullpop_head", 128'(trc_data[63:0]), 128'd5);

        // Clear wins over a same-cycle fire
        mon_valid = 3'b111; mon_ready = 3'b111; trc_ready = 1'b0; clear = 1'b1;
        cycle();
        chk("clr_level", 128'(level), 128'd0);
        chk("clr_xfer", 128'(xfer_cnt), 128'd0);
        chk("clr_drop", 128'(drop_cnt), 128'd0);
        quiet();
        cycle();
        chk("clr_noentry", 128'(level), 128'd0);
        wrap_mode = 1'b0;

        // Stalls then transfer on channel 2
        do_clear();
        mon_valid = 3'b100; mon_ready = 3'b000;
        for (int k = 0; k < 5; k++) cycle();
        mon_ready = 3'b100;
        cycle();
        quiet();
        chk("stall2", 128'(stall_cnt[95:64]), 128'd5);
        chk("xfer2", 128'(xfer_cnt[95:64]), 128'd1);

        // Randomized traffic against the model
        do_clear();
        for (int c = 0; c < 3000; c++) begin
            phase = (c / 200) % 3;
            mon_valid = 3'($urandom);
            mon_ready = 3'($urandom);
            ch_en     = 3'($urandom);
            wrap_mode = 1'($urandom);
            mon_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            trc_ready = (phase == 0) ? ($urandom_range(0, 7) == 0) :
                        (phase == 1) ? 1'($urandom) : 1'b1;
            clear     = ($urandom_range(0, 299) == 0);
            cycle();
        end
        quiet();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
